// File: rtl/rv32v_lsc_sequencer_if.sv
// Signal bundle between the RV32V vector pipeline / data memory and the LSC sequencer.
// With RV32V_LSC_MASK_EN defined the bundle also carries the per-element req_mask.
interface rv32v_lsc_sequencer_if #(
    parameter int MAXVL = 32,
    parameter int IDX_W = $clog2(MAXVL)
);
    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    logic             req_strided;
    logic [1:0]       req_eew;
    logic [31:0]      req_base;
    logic [31:0]      req_stride;
    logic [IDX_W:0]   req_vl;
`ifdef RV32V_LSC_MASK_EN
    logic [MAXVL-1:0] req_mask;
`endif
    logic [IDX_W-1:0] st_idx;
    logic [31:0]      st_data;
    logic [31:0]      mem_addr;
    logic             mem_ren;
    logic             mem_wen;
    logic [3:0]       mem_byte_en;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             mem_busy;
    logic             wb_valid;
    logic [IDX_W-1:0] wb_idx;
    logic [31:0]      wb_data;
    logic             done;
    logic             fault;
    logic [IDX_W-1:0] fault_idx;
    logic             ifence;
    logic             fence_stall;

    modport slave (
        input  req_valid, req_store, req_strided, req_eew, req_base, req_stride, req_vl,
`ifdef RV32V_LSC_MASK_EN
        input  req_mask,
`endif
        input  st_data, mem_rdata, mem_busy, ifence,
        output req_ready, st_idx, mem_addr, mem_ren, mem_wen, mem_byte_en, mem_wdata,
        output wb_valid, wb_idx, wb_data, done, fault, fault_idx, fence_stall
    );

    modport master (
        output req_valid, req_store, req_strided, req_eew, req_base, req_stride, req_vl,
`ifdef RV32V_LSC_MASK_EN
        output req_mask,
`endif
        output st_data, mem_rdata, mem_busy, ifence,
        input  req_ready, st_idx, mem_addr, mem_ren, mem_wen, mem_byte_en, mem_wdata,
        input  wb_valid, wb_idx, wb_data, done, fault, fault_idx, fence_stall
    );
endinterface

// File: rtl/rv32v_lsc_sequencer.sv
// Vector load-store sequencer: serialises one vector memory instruction into element accesses.
// Optional per-element masking is enabled by defining RV32V_LSC_MASK_EN.
//
// state | meaning
// IDLE  | waiting for an instruction, req_ready = !ifence
// ISSUE | alignment check and memory access for element idx
// WB    | write-back of the captured load element
// DONE  | one-cycle completion pulse with fault status
module rv32v_lsc_sequencer #(
    parameter int MAXVL = 32,
    parameter int IDX_W = $clog2(MAXVL)
) (
    input logic                  CLK,
    input logic                  nRST,
    rv32v_lsc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WB, DONE} state_t;

    localparam logic [IDX_W:0] VL_MAX = (IDX_W+1)'(MAXVL);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   vl_q, vl_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      stride_q, stride_d;
    logic [31:0]      data_q, data_d;
    logic             store_q, store_d;
    logic [1:0]       eew_q, eew_d;
    logic             fault_q, fault_d;
    logic [IDX_W-1:0] fidx_q, fidx_d;

    logic             active;
    logic             misaligned;
    logic             last;
    logic [1:0]       off;
    logic [3:0]       be_base;
    logic [31:0]      elem_mask;
    logic [31:0]      unit_stride;

`ifdef RV32V_LSC_MASK_EN
    logic [MAXVL-1:0] mask_q, mask_d;
    assign active = mask_q[idx_q];
`else
    assign active = 1'b1;
`endif

    assign off  = addr_q[1:0];
    assign last = (({1'b0, idx_q} + (IDX_W+1)'(1)) == vl_q);

    always_comb begin
        case (eew_q)
            2'b00:   begin be_base = 4'b0001; elem_mask = 32'h0000_00FF; end
            2'b01:   begin be_base = 4'b0011; elem_mask = 32'h0000_FFFF; end
            default: begin be_base = 4'b1111; elem_mask = 32'hFFFF_FFFF; end
        endcase
    end

    always_comb begin
        case (bus.req_eew)
            2'b00:   unit_stride = 32'd1;
            2'b01:   unit_stride = 32'd2;
            default: unit_stride = 32'd4;
        endcase
    end

    always_comb begin
        case (eew_q)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        vl_d            = vl_q;
        addr_d          = addr_q;
        stride_d        = stride_q;
        data_d          = data_q;
        store_d         = store_q;
        eew_d           = eew_q;
        fault_d         = fault_q;
        fidx_d          = fidx_q;
`ifdef RV32V_LSC_MASK_EN
        mask_d          = mask_q;
`endif
        bus.req_ready   = 1'b0;
        bus.mem_ren     = 1'b0;
        bus.mem_wen     = 1'b0;
        bus.mem_byte_en = 4'b0000;
        bus.mem_wdata   = 32'h0;
        bus.wb_valid    = 1'b0;
        bus.done        = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = !bus.ifence;
                if (bus.req_valid && !bus.ifence) begin
                    idx_d    = '0;
                    addr_d   = bus.req_base;
                    stride_d = bus.req_strided ? bus.req_stride : unit_stride;
                    store_d  = bus.req_store;
                    eew_d    = bus.req_eew;
                    fault_d  = 1'b0;
                    fidx_d   = '0;
                    vl_d     = (bus.req_vl > VL_MAX) ? VL_MAX : bus.req_vl;
`ifdef RV32V_LSC_MASK_EN
                    mask_d   = bus.req_mask;
`endif
                    state_d  = (vl_d == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (!active) begin
                    idx_d   = idx_q + IDX_W'(1);
                    addr_d  = addr_q + stride_q;
                    state_d = last ? DONE : ISSUE;
                end else if (misaligned) begin
                    fault_d = 1'b1;
                    fidx_d  = idx_q;
                    state_d = DONE;
                end else begin
                    bus.mem_ren     = !store_q;
                    bus.mem_wen     = store_q;
                    bus.mem_byte_en = be_base << off;
                    if (store_q) begin
                        bus.mem_wdata = bus.st_data << {off, 3'b000};
                    end
                    // Address and data stay put until the memory releases busy.
                    if (!bus.mem_busy) begin
                        addr_d = addr_q + stride_q;
                        if (store_q) begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = last ? DONE : ISSUE;
                        end else begin
                            data_d  = (bus.mem_rdata >> {off, 3'b000}) & elem_mask;
                            state_d = WB;
                        end
                    end
                end
            end
            WB: begin
                bus.wb_valid = 1'b1;
                idx_d        = idx_q + IDX_W'(1);
                state_d      = last ? DONE : ISSUE;
            end
            DONE: begin
                bus.done = 1'b1;
                fault_d  = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr    = addr_q;
    assign bus.st_idx      = idx_q;
    assign bus.wb_idx      = idx_q;
    assign bus.wb_data     = data_q;
    assign bus.fault       = fault_q;
    assign bus.fault_idx   = fidx_q;
    assign bus.fence_stall = bus.ifence && (state_q != IDLE);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            vl_q     <= '0;
            addr_q   <= '0;
            stride_q <= '0;
            data_q   <= '0;
            store_q  <= 1'b0;
            eew_q    <= 2'b00;
            fault_q  <= 1'b0;
            fidx_q   <= '0;
`ifdef RV32V_LSC_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            vl_q     <= vl_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            data_q   <= data_d;
            store_q  <= store_d;
            eew_q    <= eew_d;
            fault_q  <= fault_d;
            fidx_q   <= fidx_d;
`ifdef RV32V_LSC_MASK_EN
            mask_q   <= mask_d;
`endif
        end
    end
endmodule

// File: tb/tb_rv32v_lsc_sequencer.sv
// Randomised self-checking bench for rv32v_lsc_sequencer with a list-based instruction model.
// Define RV32V_LSC_MASK_EN to also exercise masked elements.
`timescale 1ns/1ps
module tb_rv32v_lsc_sequencer;
    localparam int MAXVL = 32;
    localparam int IDX_W = $clog2(MAXVL);

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    rv32v_lsc_sequencer_if #(.MAXVL(MAXVL)) bus();
    rv32v_lsc_sequencer #(.MAXVL(MAXVL)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    int checks = 0;
    int errors = 0;

    logic [31:0] vrf [MAXVL];
    acc_t        exp_acc[$], obs_acc[$];
    int          exp_wb_idx[$], obs_wb_idx[$];
    logic [31:0] exp_wb_dat[$], obs_wb_dat[$];
    int          exp_done_cyc;
    bit          exp_fault;
    int          exp_fidx;

    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234 ^ {w[15:0], w[31:16]};
    endfunction

    // Walk the element list with plain arithmetic: address = base + i*stride.
    task automatic build_expect(input bit store, input bit strided, input logic [1:0] eew,
                                input logic [31:0] base, input logic [31:0] stride, input int vl,
                                input logic [MAXVL-1:0] mask, input int waits);
        int n, nbytes, off, cyc, b;
        logic [31:0] st, a, emask;
        acc_t x;
        exp_acc.delete(); exp_wb_idx.delete(); exp_wb_dat.delete();
        exp_fault = 0; exp_fidx = 0; cyc = 0;
        n      = (vl > MAXVL) ? MAXVL : vl;
        nbytes = (eew == 2'd0) ? 1 : (eew == 2'd1) ? 2 : 4;
        st     = strided ? stride : 32'(nbytes);
        emask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
        for (int i = 0; i < n; i++) begin
            a = base + st * 32'(i);
            if (!mask[i]) begin
                cyc += 1;
                continue;
            end
            if (eew == 2'd3 || (a % nbytes) != 0) begin
                exp_fault = 1; exp_fidx = i; cyc += 1;
                break;
            end
            off    = int'(a % 4);
            b      = ((1 << nbytes) - 1) << off;
            x.addr = a;
            x.be   = b[3:0];
            x.wdata = store ? (vrf[i] << (8 * off)) : 32'h0;
            exp_acc.push_back(x);
            cyc += 1 + waits;
            if (!store) begin
                exp_wb_idx.push_back(i);
                exp_wb_dat.push_back((memword(a) >> (8 * off)) & emask);
                cyc += 1;
            end
        end
        exp_done_cyc = cyc + 1;
    endtask

    task automatic run_instr(input bit store, input bit strided, input logic [1:0] eew,
                             input logic [31:0] base, input logic [31:0] stride, input int vl,
                             input logic [MAXVL-1:0] mask, input int waits, input int fence_at);
        int   cyc, wleft, done_cyc;
        bit   got_done, in_acc, strobe, dfault;
        int   dfidx;
        acc_t cur;
        build_expect(store, strided, eew, base, stride, vl, mask, waits);
        obs_acc.delete(); obs_wb_idx.delete(); obs_wb_dat.delete();
        for (int i = 0; i < MAXVL; i++) vrf[i] = vrf[i];
        @(negedge CLK);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL req_ready_idle: got %b expected 1", bus.req_ready);
        end
        bus.req_valid   = 1'b1;
        bus.req_store   = store;
        bus.req_strided = strided;
        bus.req_eew     = eew;
        bus.req_base    = base;
        bus.req_stride  = stride;
        bus.req_vl      = (IDX_W+1)'(vl);
`ifdef RV32V_LSC_MASK_EN
        bus.req_mask    = mask;
`endif
        @(posedge CLK); #1;
        bus.req_valid  = 1'b0;
        bus.req_store  = $urandom_range(0, 1);
        bus.req_eew    = 2'($urandom);
        bus.req_base   = $urandom;
        bus.req_stride = $urandom;
        bus.req_vl     = (IDX_W+1)'($urandom);
        cyc = 0; wleft = 0; got_done = 0; in_acc = 0; done_cyc = 0; dfault = 0; dfidx = 0;
        cur = '{addr: 32'h0, be: 4'h0, wdata: 32'h0};
        while (!got_done && cyc < 3000) begin
            @(negedge CLK);
            cyc++;
            if (fence_at != 0 && cyc == fence_at) bus.ifence = 1'b1;
            bus.st_data = vrf[bus.st_idx];
            #1;
            checks++;
            if (bus.fence_stall !== bus.ifence) begin
                errors++; $display("FAIL fence_stall: cycle %0d got %b expected %b", cyc, bus.fence_stall, bus.ifence);
            end
            if (bus.ifence) begin
                checks++;
                if (bus.req_ready !== 1'b0) begin
                    errors++; $display("FAIL req_ready_fence: got %b expected 0", bus.req_ready);
                end
            end
            strobe = bus.mem_ren | bus.mem_wen;
            if (strobe) begin
                checks++;
                if (bus.mem_wen !== store || bus.mem_ren !== !store) begin
                    errors++; $display("FAIL strobe_kind: ren %b wen %b expected store=%b", bus.mem_ren, bus.mem_wen, store);
                end
                if (!in_acc) begin
                    in_acc    = 1;
                    wleft     = waits;
                    cur.addr  = bus.mem_addr;
                    cur.be    = bus.mem_byte_en;
                    cur.wdata = store ? bus.mem_wdata : 32'h0;
                end else begin
                    checks++;
                    if (bus.mem_addr !== cur.addr || bus.mem_byte_en !== cur.be ||
                        (store && bus.mem_wdata !== cur.wdata)) begin
                        errors++; $display("FAIL busy_stable: addr %h be %b wdata %h expected %h %b %h",
                                           bus.mem_addr, bus.mem_byte_en, bus.mem_wdata, cur.addr, cur.be, cur.wdata);
                    end
                end
                if (wleft > 0) begin
                    wleft--;
                    bus.mem_busy  = 1'b1;
                    bus.mem_rdata = $urandom;
                end else begin
                    bus.mem_busy  = 1'b0;
                    bus.mem_rdata = memword(bus.mem_addr);
                    obs_acc.push_back(cur);
                    in_acc = 0;
                end
            end else begin
                bus.mem_busy  = 1'($urandom_range(0, 1));
                bus.mem_rdata = $urandom;
            end
            if (bus.wb_valid) begin
                obs_wb_idx.push_back(int'(bus.wb_idx));
                obs_wb_dat.push_back(bus.wb_data);
            end
            if (bus.done) begin
                got_done = 1; done_cyc = cyc; dfault = bus.fault; dfidx = int'(bus.fault_idx);
            end
        end
        bus.mem_busy = 1'b0;
        checks++;
        if (!got_done) begin
            errors++; $display("FAIL done_timeout: no done within %0d cycles", cyc);
        end
        checks++;
        if (done_cyc != exp_done_cyc) begin
            errors++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc, exp_done_cyc);
        end
        checks++;
        if (dfault !== exp_fault) begin
            errors++; $display("FAIL fault: got %b expected %b", dfault, exp_fault);
        end
        if (exp_fault) begin
            checks++;
            if (dfidx != exp_fidx) begin
                errors++; $display("FAIL fault_idx: got %0d expected %0d", dfidx, exp_fidx);
            end
        end
        checks++;
        if (obs_acc.size() != exp_acc.size()) begin
            errors++; $display("FAIL access_count: got %0d expected %0d", obs_acc.size(), exp_acc.size());
        end
        for (int i = 0; i < exp_acc.size() && i < obs_acc.size(); i++) begin
            checks++;
            if (obs_acc[i].addr !== exp_acc[i].addr || obs_acc[i].be !== exp_acc[i].be ||
                obs_acc[i].wdata !== exp_acc[i].wdata) begin
                errors++; $display("FAIL access_%0d: got %h/%b/%h expected %h/%b/%h", i,
                                   obs_acc[i].addr, obs_acc[i].be, obs_acc[i].wdata,
                                   exp_acc[i].addr, exp_acc[i].be, exp_acc[i].wdata);
            end
        end
        checks++;
        if (obs_wb_idx.size() != exp_wb_idx.size()) begin
            errors++; $display("FAIL wb_count: got %0d expected %0d", obs_wb_idx.size(), exp_wb_idx.size());
        end
        for (int i = 0; i < exp_wb_idx.size() && i < obs_wb_idx.size(); i++) begin
            checks++;
            if (obs_wb_idx[i] != exp_wb_idx[i] || obs_wb_dat[i] !== exp_wb_dat[i]) begin
                errors++; $display("FAIL wb_%0d: got idx %0d data %h expected idx %0d data %h", i,
                                   obs_wb_idx[i], obs_wb_dat[i], exp_wb_idx[i], exp_wb_dat[i]);
            end
        end
        @(negedge CLK); #1;
        checks++;
        if (bus.req_ready !== !bus.ifence || bus.fence_stall !== 1'b0 || bus.fault !== 1'b0) begin
            errors++; $display("FAIL after_done: ready %b stall %b fault %b expected %b 0 0",
                               bus.req_ready, bus.fence_stall, bus.fault, !bus.ifence);
        end
        if (bus.ifence) begin
            bus.ifence = 1'b0;
            #1;
            checks++;
            if (bus.req_ready !== 1'b1) begin
                errors++; $display("FAIL ready_after_fence: got %b expected 1", bus.req_ready);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 ||
            bus.mem_byte_en !== 4'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_mem: ready %b ren %b wen %b be %b addr %h wdata %h expected 1 0 0 0 0 0",
                               bus.req_ready, bus.mem_ren, bus.mem_wen, bus.mem_byte_en, bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.wb_valid !== 1'b0 || bus.wb_idx !== '0 || bus.wb_data !== 32'h0 || bus.done !== 1'b0 ||
            bus.fault !== 1'b0 || bus.fault_idx !== '0 || bus.st_idx !== '0 || bus.fence_stall !== 1'b0) begin
            errors++; $display("FAIL reset_status: wbv %b wbi %0d wbd %h done %b fault %b fidx %0d stidx %0d stall %b expected all 0",
                               bus.wb_valid, bus.wb_idx, bus.wb_data, bus.done, bus.fault, bus.fault_idx,
                               bus.st_idx, bus.fence_stall);
        end
        nRST = 1'b1;
    endtask

    task automatic test_unit_load();
        run_instr(1'b0, 1'b0, 2'd2, 32'h1000, 32'h0, 4, '1, 0, 0);
    endtask

    task automatic test_strided_store();
        run_instr(1'b1, 1'b1, 2'd0, 32'h2003, 32'hFFFF_FFFD, 3, '1, 0, 0);
    endtask

    task automatic test_misaligned();
        run_instr(1'b0, 1'b1, 2'd1, 32'h10, 32'd3, 4, '1, 0, 0);
    endtask

    task automatic test_wait_fence();
        run_instr(1'b0, 1'b0, 2'd2, 32'h40, 32'h0, 3, '1, 3, 4);
    endtask

    task automatic test_edges();
        run_instr(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 0, '1, 0, 0);
        run_instr(1'b1, 1'b0, 2'd0, 32'h303, 32'h0, MAXVL + 5, '1, 0, 0);
        run_instr(1'b0, 1'b1, 2'd3, 32'h500, 32'd4, 2, '1, 0, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_strided = 1'b0;
        bus.req_eew = 2'd2; bus.req_base = 32'h800; bus.req_vl = (IDX_W+1)'(4);
`ifdef RV32V_LSC_MASK_EN
        bus.req_mask = '1;
`endif
        bus.mem_busy = 1'b1;
        @(posedge CLK); #1;
        bus.req_valid = 1'b0;
        @(negedge CLK); #1;
        checks++;
        if (bus.mem_ren !== 1'b1 || bus.req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_pre: ren %b ready %b expected 1 0", bus.mem_ren, bus.req_ready);
        end
        nRST = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 || bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rst_mid_post: ren %b wen %b ready %b done %b expected 0 0 1 0",
                               bus.mem_ren, bus.mem_wen, bus.req_ready, bus.done);
        end
        nRST = 1'b1;
        bus.mem_busy = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  eew;
        logic [31:0] base, stride;
        logic [MAXVL-1:0] mask;
        int r;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < MAXVL; i++) vrf[i] = $urandom;
            r    = $urandom_range(0, 9);
            eew  = (r == 9) ? 2'd3 : 2'(r % 3);
            base = $urandom;
            if ($urandom_range(0, 3) != 0) base[1:0] = 2'b00;
            stride = 32'($signed($urandom_range(0, 32)) - 16);
            mask = '1;
`ifdef RV32V_LSC_MASK_EN
            mask = MAXVL'({$urandom, $urandom});
`endif
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), eew, base, stride,
                      $urandom_range(0, MAXVL + 3), mask, $urandom_range(0, 2),
                      ($urandom_range(0, 4) == 0) ? 2 : 0);
        end
    endtask

`ifdef RV32V_LSC_MASK_EN
    task automatic test_mask();
        logic [MAXVL-1:0] m;
        m = '0;
        m[0] = 1'b1;
        m[2] = 1'b1;
        run_instr(1'b0, 1'b1, 2'd2, 32'h1000, 32'h6, 4, m, 0, 0);
    endtask
`endif

    initial begin
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_strided = 1'b0; bus.req_eew = 2'd0;
        bus.req_base = 32'h0; bus.req_stride = 32'h0; bus.req_vl = '0;
`ifdef RV32V_LSC_MASK_EN
        bus.req_mask = '1;
`endif
        bus.st_data = 32'hDEAD_BEEF; bus.mem_rdata = 32'h0; bus.mem_busy = 1'b0; bus.ifence = 1'b0;
        for (int i = 0; i < MAXVL; i++) vrf[i] = $urandom;
        test_reset();
        test_unit_load();
        test_strided_store();
        test_misaligned();
        test_wait_fence();
        test_edges();
        test_reset_mid();
`ifdef RV32V_LSC_MASK_EN
        test_mask();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv32v_lsc_sequencer.md
# rv32v_lsc_sequencer

Parametrised vector load-store sequencer for the RV32V core; the next generation of the scalar/vector load-store mux. Accepts one whole vector memory instruction (unit-stride or strided, 8/16/32-bit elements, up to MAXVL elements) and serialises it into single-element accesses on the data-memory port. Load elements are written back to the vector register file one at a time. Completion, misalignment faults and ifence stalls are reported to the vector pipeline.

## Interface
Parameters:
- MAXVL, 32, maximum elements per instruction (power of two, ≥2)
- IDX_W, $clog2(MAXVL), element index width (derived; do not override)

Ports (reset is synchronous and active-low: nRST is sampled only on the rising edge of CLK):
- CLK  in  1  core clock
- nRST  in  1  synchronous active-low reset
- req_valid  in  1  vector memory instruction offered
- req_ready  out  1  sequencer can accept
- req_store  in  1  1 = store, 0 = load
- req_strided  in  1  1 = strided, 0 = unit-stride
- req_eew  in  2  00 = 8b, 01 = 16b, 10 = 32b, 11 = reserved
- req_base  in  32  base byte address
- req_stride  in  32  byte stride (strided mode only; two's complement)
- req_vl  in  IDX_W+1  element count
- req_mask  in  MAXVL  per-element enable (present only with RV32V_LSC_MASK_EN)
- st_idx  out  IDX_W  element index the store data is read from
- st_data  in  32  VRF element, right-justified, same cycle as st_idx
- mem_addr  out  32  access address
- mem_ren / mem_wen  out  1 each  read / write strobe
- mem_byte_en  out  4  byte lanes
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  load data, valid when busy is low
- mem_busy  in  1  access not complete
- wb_valid  out  1  load element write-back strobe
- wb_idx  out  IDX_W  write-back element index
- wb_data  out  32  element, right-justified, zero-extended
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done: misalignment or reserved eew
- fault_idx  out  IDX_W  first faulting element
- ifence  in  1  instruction fence request
- fence_stall  out  1  fence must wait

## Operation
- States: IDLE, ISSUE, WB, DONE.
- IDLE: req_ready = !ifence. On req_valid && req_ready, latch the request and set idx=0, cur_addr=req_base, vl=min(req_vl, MAXVL). Go to DONE if vl==0, otherwise go to ISSUE.
- Effective stride: eew bytes (1/2/4) in unit-stride mode, req_stride in strided mode. cur_addr += stride after each element, modulo 2^32.
- ISSUE: check alignment combinationally. A fault occurs when eew=16 and addr[0]=1, when eew=32 and addr[1:0]≠0, or when eew=11.
  - On fault: no strobe; set fault=1, fault_idx=idx; go to DONE. Elements before idx remain completed.
  - Otherwise assert mem_ren or mem_wen, held with stable addr/data until mem_busy=0.
  - mem_byte_en = {0001, 0011, 1111}[eew] << addr[1:0].
  - mem_wdata = st_data << 8·addr[1:0], with st_idx=idx.
- On the cycle a load completes (busy=0), capture (mem_rdata >> 8·addr[1:0]) masked to eew, then go to WB.
- On the cycle a store completes, advance idx.
- In ISSUE and after a store advances idx: go to DONE if idx+1==vl, otherwise stay in ISSUE.
- WB: wb_valid=1 for one cycle with wb_idx=idx and the captured data. Advance idx, then go to ISSUE or DONE.
- DONE: done=1 for one cycle with fault/fault_idx valid; fault clears on leaving. Go to IDLE.
- fence_stall = ifence && state≠IDLE. An ifence raised mid-instruction does not abort it.

## Timing
- Reset values: req_ready=1, mem_ren=mem_wen=0, mem_byte_en=0, mem_addr=0, mem_wdata=0, wb_valid=0, wb_idx=0, wb_data=0, done=0, fault=0, fault_idx=0, st_idx=0, fence_stall=0.
- Accept edge = cycle 0. The first strobe appears in cycle 1.
- With zero-wait memory: 1 cycle per store element and 2 cycles per load element (ISSUE+WB). done is asserted the cycle after the last access or write-back.
- vl=0: done in cycle 1, no memory strobe.
- Reset asserted mid-instruction: at the next edge all strobes drop and the state goes to IDLE. The abandoned access is the memory side's concern.
- Request inputs are don't-care outside the accept cycle.

## Configuration
- RV32V_LSC_MASK_EN defined:
  - The req_mask port exists and is latched at accept.
  - In ISSUE, an element with mask[idx]=0 produces no strobe and no write-back; it consumes one ISSUE cycle and advances idx.
  - Masked elements are not alignment-checked; cur_addr still advances.
- RV32V_LSC_MASK_EN undefined: the port is absent and all elements are active.

## Test plan
- Unit-stride load: eew=32, base=0x1000, vl=4, zero-wait memory -> reads at 0x1000/4/8/C with byte_en=1111; wb_idx 0..3; done at cycle 9.
- Strided byte store: eew=8, base=0x2003, stride=-3, vl=3 -> addresses 0x2003/0x2000/0x1FFD, byte_en 1000/0001/0010, wdata lanes shifted to match; done at cycle 4.
- Misaligned halfword: eew=16, strided, base=0x10, stride=3, vl=4 -> elements 0 and 1 (0x10 and 0x13) behave as follows: element 0 accessed; element 1 (0x13 odd) faults with no strobe; done with fault=1, fault_idx=1.
- Wait states and fence: mem_busy held 3 cycles per access, ifence raised mid-load -> strobes and addr stable while busy; fence_stall=1 until IDLE; req_ready=0 while ifence is high.
- Edge cases: vl=0 -> done cycle 1, no strobe. req_vl=MAXVL+5 -> exactly MAXVL accesses. nRST low during ISSUE -> strobes 0 and req_ready=1 after the edge.
- With RV32V_LSC_MASK_EN: load vl=4, mask=0101 -> accesses only for elements 0 and 2; wb_idx 0 and 2; element 1 at a misaligned address raises no fault.
